// File: rtl/clm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clm_arb_pkg
// Brief   : Shared types and helpers for the CLM read-port arbiter.
// Revision: 1.0
// ============================================================================
package clm_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int C_MAX_NR = 8;

    // Index width for n entries, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // First asserted request scanning ptr, ptr+1, ... modulo nr.
    function automatic logic [2:0] rr_next(input logic [C_MAX_NR-1:0] req,
                                           input logic [2:0]          ptr,
                                           input int                  nr);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < C_MAX_NR; i++) begin
            idx = (int'(ptr) + i) % nr;
            if ((i < nr) && !found && req[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clm_ord_fifo.sv
`default_nettype none
// ============================================================================
// Module  : clm_ord_fifo
// Brief   : Grant-order FIFO; holds requester indices of outstanding bursts.
// Revision: 1.0
// ============================================================================
module clm_ord_fifo
    import clm_arb_pkg::*;
#(
    parameter int OD = 4,
    parameter int W  = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty
);

    localparam int PW = idx_w(OD);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic [W-1:0]  r_mem [OD];
    logic          w_push;
    logic          w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign full   = (r_count == (PW+1)'(OD));
    assign empty  = (r_count == '0);
    assign dout   = r_mem[r_rd_ptr];

    // Depth is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/clm_rd_arb.sv
`default_nettype none
// ============================================================================
// Module  : clm_rd_arb
// Brief   : Round-robin burst arbiter for the CLM read port with in-order
//           return-data steering.
// Revision: 1.0
// ============================================================================
module clm_rd_arb
    import clm_arb_pkg::*;
#(
    parameter int NR = 3,
    parameter int AW = 32,
    parameter int DW = 64,
    parameter int OD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NR*AW-1:0] m_addr,
    input  logic [NR-1:0]    m_addr_first,
    input  logic [NR-1:0]    m_addr_last,
    input  logic [NR-1:0]    m_addr_valid,
    output logic [NR-1:0]    m_addr_ready,
    output logic [AW-1:0]    s_addr,
    output logic             s_addr_first,
    output logic             s_addr_last,
    output logic             s_addr_valid,
    input  logic             s_addr_ready,
    input  logic [DW-1:0]    m_data,
    input  logic             m_data_first,
    input  logic             m_data_last,
    input  logic             m_data_valid,
    output logic             m_data_ready,
    output logic [NR*DW-1:0] s_data,
    output logic [NR-1:0]    s_data_first,
    output logic [NR-1:0]    s_data_last,
    output logic [NR-1:0]    s_data_valid,
    input  logic [NR-1:0]    s_data_ready
);

    localparam int GW = idx_w(NR);

    arb_state_t        r_state;
    logic [GW-1:0]     r_gnt;
    logic [GW-1:0]     r_ptr;
    logic [C_MAX_NR-1:0] w_req;
    logic [2:0]        w_ptr3;
    logic [2:0]        w_pick;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [GW-1:0]     w_head;
    logic [AW-1:0]     w_addr_arr [NR];

    for (genvar i = 0; i < NR; i++) begin : g_split
        assign w_addr_arr[i] = m_addr[i*AW +: AW];
    end

    always_comb begin
        w_req              = '0;
        w_req[NR-1:0]      = m_addr_valid;
        w_ptr3             = '0;
        w_ptr3[GW-1:0]     = r_ptr;
    end

    assign w_pick = rr_next(w_req, w_ptr3, NR);
    assign w_push = (r_state == IDLE) && (|m_addr_valid) && !w_full;

    // The grant is held until the last beat of the burst is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_push) begin
                        r_gnt   <= w_pick[GW-1:0];
                        r_state <= BURST;
                    end
                end
                BURST: begin
                    if (s_addr_valid && s_addr_ready && s_addr_last) begin
                        r_state <= IDLE;
                        r_ptr   <= (r_gnt == GW'(NR-1)) ? '0 : r_gnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_addr       = w_addr_arr[r_gnt];
        s_addr_first = m_addr_first[r_gnt];
        s_addr_last  = m_addr_last[r_gnt];
        s_addr_valid = (r_state == BURST) && m_addr_valid[r_gnt];
        m_addr_ready = '0;
        if (r_state == BURST) m_addr_ready[r_gnt] = s_addr_ready;
    end

    clm_ord_fifo #(
        .OD (OD),
        .W  (GW)
    ) u_ord_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   (w_pick[GW-1:0]),
        .full  (w_full),
        .pop   (w_pop),
        .dout  (w_head),
        .empty (w_empty)
    );

    assign w_pop  = !w_empty && m_data_valid && m_data_ready && m_data_last;
    assign s_data = {NR{m_data}};

    always_comb begin
        s_data_valid = '0;
        s_data_first = '0;
        s_data_last  = '0;
        m_data_ready = 1'b0;
        if (!w_empty) begin
            s_data_valid[w_head] = m_data_valid;
            s_data_first[w_head] = m_data_first;
            s_data_last[w_head]  = m_data_last;
            m_data_ready         = s_data_ready[w_head];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clm_rd_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_clm_rd_arb
// Brief   : Randomized bench for clm_rd_arb against a transaction-level model.
// Revision: 1.0
// ============================================================================
module tb_clm_rd_arb;

    localparam int NR = 3;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int OD = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NR*AW-1:0] m_addr;
    logic [NR-1:0]    m_addr_first, m_addr_last, m_addr_valid, m_addr_ready;
    logic [AW-1:0]    s_addr;
    logic             s_addr_first, s_addr_last, s_addr_valid, s_addr_ready;
    logic [DW-1:0]    m_data;
    logic             m_data_first, m_data_last, m_data_valid, m_data_ready;
    logic [NR*DW-1:0] s_data;
    logic [NR-1:0]    s_data_first, s_data_last, s_data_valid, s_data_ready;

    clm_rd_arb #(.NR(NR), .AW(AW), .DW(DW), .OD(OD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m_addr       (m_addr),
        .m_addr_first (m_addr_first),
        .m_addr_last  (m_addr_last),
        .m_addr_valid (m_addr_valid),
        .m_addr_ready (m_addr_ready),
        .s_addr       (s_addr),
        .s_addr_first (s_addr_first),
        .s_addr_last  (s_addr_last),
        .s_addr_valid (s_addr_valid),
        .s_addr_ready (s_addr_ready),
        .m_data       (m_data),
        .m_data_first (m_data_first),
        .m_data_last  (m_data_last),
        .m_data_valid (m_data_valid),
        .m_data_ready (m_data_ready),
        .s_data       (s_data),
        .s_data_first (s_data_first),
        .s_data_last  (s_data_last),
        .s_data_valid (s_data_valid),
        .s_data_ready (s_data_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Requester-side stimulus state
    bit          rq_vld [NR];
    bit          rq_act [NR];
    int          rq_beat[NR];
    int          rq_len [NR];
    logic [AW-1:0] rq_base[NR];

    // Stimulus knobs
    logic [NR-1:0] en;
    int  p_req, p_sready, p_dv, p_lr, fix_len;
    bit  fix_base, stall;

    // Reference model: grant state, order of outstanding bursts, CLM backlog
    bit  mb_busy;
    int  mb_gnt, mb_ptr;
    int  oq[$];
    int  clm_q[$];
    int  clm_cnt;
    bit  cd_vld;
    int  cd_beat;
    logic [DW-1:0] cd_data;

    function automatic bit roll(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            m_addr[i*AW +: AW] = rq_base[i] + AW'(8 * rq_beat[i]);
            m_addr_first[i]    = (rq_beat[i] == 0);
            m_addr_last[i]     = (rq_beat[i] == rq_len[i] - 1);
            m_addr_valid[i]    = rq_vld[i];
        end
        m_data       = cd_data;
        m_data_valid = cd_vld;
        m_data_first = (cd_beat == 0);
        m_data_last  = (clm_q.size() > 0) && (cd_beat == clm_q[0] - 1);
    endtask

    task automatic reset_model();
        mb_busy = 0; mb_gnt = 0; mb_ptr = 0;
        oq.delete(); clm_q.delete(); clm_cnt = 0;
        cd_vld = 0; cd_beat = 0; cd_data = '0;
        for (int i = 0; i < NR; i++) begin
            rq_vld[i] = 0; rq_act[i] = 0; rq_beat[i] = 0; rq_len[i] = 1; rq_base[i] = '0;
        end
    endtask

    task automatic step();
        logic [NR-1:0] e_rdy, e_dv, e_df, e_dl;
        int  h, pick;
        bit  a_hs, d_hs, a_last, rs, was_full, do_push;
        @(negedge clk);
        rs = rst_n;
        e_rdy = '0;
        if (mb_busy && s_addr_ready) e_rdy[mb_gnt] = 1'b1;
        check_eq("m_addr_ready", 64'(m_addr_ready), 64'(e_rdy));
        check_eq("s_addr_valid", 64'(s_addr_valid), 64'(mb_busy && rq_vld[mb_gnt]));
        a_last = (rq_beat[mb_gnt] == rq_len[mb_gnt] - 1);
        if (mb_busy && rq_vld[mb_gnt]) begin
            check_eq("s_addr", 64'(s_addr), 64'(rq_base[mb_gnt] + AW'(8 * rq_beat[mb_gnt])));
            check_eq("s_addr_fl", 64'({s_addr_first, s_addr_last}),
                     64'({rq_beat[mb_gnt] == 0, a_last}));
        end
        e_dv = '0; e_df = '0; e_dl = '0; h = -1;
        if (oq.size() > 0) begin
            h = oq[0];
            e_dv[h] = m_data_valid; e_df[h] = m_data_first; e_dl[h] = m_data_last;
        end
        check_eq("s_data_vfl", 64'({s_data_valid, s_data_first, s_data_last}), 64'({e_dv, e_df, e_dl}));
        check_eq("m_data_ready", 64'(m_data_ready), 64'((h >= 0) ? s_data_ready[h] : 1'b0));
        if (h >= 0 && m_data_valid)
            check_eq("s_data_lane", 64'(s_data[h*DW +: DW]), 64'(m_data));
        a_hs = mb_busy && rq_vld[mb_gnt] && s_addr_ready;
        d_hs = (h >= 0) && m_data_valid && s_data_ready[h];

        @(posedge clk);
        #1;
        if (!rs) begin
            reset_model();
        end else begin
            was_full = (oq.size() >= OD);
            do_push  = 0;
            pick     = 0;
            if (!mb_busy) begin
                if (!was_full) begin
                    pick = -1;
                    for (int k = 0; k < NR; k++)
                        if (pick < 0 && rq_vld[(mb_ptr + k) % NR]) pick = (mb_ptr + k) % NR;
                    if (pick >= 0) begin
                        mb_gnt = pick; mb_busy = 1; do_push = 1;
                    end
                end
            end else if (a_hs && a_last) begin
                mb_busy = 0;
                mb_ptr  = (mb_gnt + 1) % NR;
            end
            if (d_hs && m_data_last) void'(oq.pop_front());
            if (do_push) oq.push_back(pick);
            if (a_hs) begin
                clm_cnt++;
                if (a_last) begin clm_q.push_back(clm_cnt); clm_cnt = 0; end
                rq_vld[mb_gnt] = 0;
                rq_beat[mb_gnt]++;
                if (rq_beat[mb_gnt] == rq_len[mb_gnt]) begin
                    rq_act[mb_gnt] = 0; rq_beat[mb_gnt] = 0;
                end
            end
            if (d_hs) begin
                cd_vld = 0;
                cd_beat++;
                if (cd_beat == clm_q[0]) begin void'(clm_q.pop_front()); cd_beat = 0; end
            end
            for (int i = 0; i < NR; i++) begin
                if (!rq_vld[i]) begin
                    if (rq_act[i]) begin
                        rq_vld[i] = roll(p_req);
                    end else if (en[i] && roll(p_req)) begin
                        rq_act[i]  = 1; rq_vld[i] = 1; rq_beat[i] = 0;
                        rq_len[i]  = (fix_len > 0) ? fix_len : $urandom_range(1, 4);
                        rq_base[i] = fix_base ? 32'h100 : ($urandom & 32'hFFFF_FFF8);
                    end
                end
            end
            if (!cd_vld && clm_q.size() > 0 && !stall && roll(p_dv)) begin
                cd_vld  = 1;
                cd_data = {$urandom, $urandom};
            end
        end
        s_addr_ready = roll(p_sready);
        for (int i = 0; i < NR; i++) s_data_ready[i] = roll(p_lr);
        drive_inputs();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        bit found;
        en = '0; p_req = 0; p_sready = 100; p_dv = 100; p_lr = 100;
        fix_len = 0; fix_base = 0; stall = 0;
        reset_model();
        s_addr_ready = 1'b0; s_data_ready = '0;
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        run(2);
        rst_n = 1'b1;

        // Requester 1 alone, 4-beat bursts from 0x100
        en = 3'b010; p_req = 100; fix_len = 4; fix_base = 1;
        run(30);
        en = '0; run(10);

        // All requesters continuously valid, 2-beat bursts, then requester 1 idle
        fix_base = 0; fix_len = 2; en = 3'b111;
        run(60);
        en = 3'b101; run(60);

        // Single-beat bursts with lane backpressure
        fix_len = 1; p_lr = 50; run(60);

        // Return data withheld: order FIFO fills, then drains
        fix_len = 0; en = 3'b111; p_lr = 100; stall = 1;
        run(60);
        stall = 0; run(60);

        // Fully random traffic
        p_req = 60; p_sready = 70; p_dv = 60; p_lr = 70;
        run(1500);

        // Reset in the middle of a requester-1 burst
        found = 0;
        for (int t = 0; t < 400 && !found; t++) begin
            step();
            if (mb_busy && mb_gnt == 1 && rq_beat[1] > 0) found = 1;
        end
        check_eq("midburst_reached", 64'(found), 64'(1));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        run(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
